// File: rtl/spi_seq_pkg.sv
// Shared state encoding and SPI command opcodes for the register-access sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        ADDR,
        DATA,
        WAIT_WR,
        CS_HOLD,
        GAP
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock divider: CLK_DIV cycles low then CLK_DIV high per bit, with
// one-cycle rise/fall strobes; run=0 parks sclk low and restarts the bit phase.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 8'd0;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= 8'd0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= 8'd0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Strobes mark the cycle whose closing edge changes sclk.
    assign rise = run && (cnt == LAST) && !phase;
    assign fall = run && (cnt == LAST) && phase;
    assign sclk = phase;

endmodule

// File: rtl/spi_sequencer.sv
// SPI register-access sequencer: cmd, addr, 1..8 data bytes under one chip select.
// Write bytes are pulled with wr_valid/wr_ready; a missing byte stalls with sclk parked low.
module spi_sequencer
    import spi_seq_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [2:0] req_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam logic [15:0] EDGE_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

    state_t      state, state_next;
    logic [15:0] tcnt;
    logic        txn_write;
    logic [7:0]  txn_addr;
    logic [2:0]  txn_len;
    logic [2:0]  byte_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  sh_out;
    logic [7:0]  sh_in;
    logic        run, rise, fall, byte_end, wr_take;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .sclk (sclk_o),
        .rise (rise),
        .fall (fall)
    );

    assign run      = (state == CMD) || (state == ADDR) || (state == DATA);
    assign byte_end = fall && (bit_cnt == 3'd7);
    assign wr_take  = wr_ready && wr_valid;
    assign busy     = (state != IDLE);
    assign cs_n_o   = (state == IDLE) || (state == GAP);
    assign mosi_o   = cs_n_o ? 1'b0 : sh_out[7];

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) state_next = CS_SETUP;
            end
            CS_SETUP: if (tcnt == EDGE_LAST) state_next = CMD;
            CMD:      if (byte_end) state_next = ADDR;
            ADDR: begin
                if (byte_end) begin
                    if (txn_write) begin
                        wr_ready   = 1'b1;
                        state_next = wr_valid ? DATA : WAIT_WR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_end) begin
                    if (byte_cnt == txn_len) begin
                        state_next = CS_HOLD;
                    end else if (txn_write) begin
                        wr_ready   = 1'b1;
                        state_next = wr_valid ? DATA : WAIT_WR;
                    end
                end
            end
            WAIT_WR: begin
                wr_ready = 1'b1;
                if (wr_valid) state_next = DATA;
            end
            CS_HOLD: if (tcnt == EDGE_LAST) state_next = GAP;
            GAP:     if (tcnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= 16'd0;
        end else begin
            state <= state_next;
            tcnt  <= (state_next != state) ? 16'd0 : tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_write <= 1'b0;
            txn_addr  <= 8'h00;
            txn_len   <= 3'd0;
            byte_cnt  <= 3'd0;
            bit_cnt   <= 3'd0;
            sh_out    <= 8'h00;
            sh_in     <= 8'h00;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= (state == CS_HOLD) && (state_next == GAP);

            if (state == IDLE && req_ready && req_valid) begin
                txn_write <= req_write;
                txn_addr  <= req_addr;
                txn_len   <= req_len;
                byte_cnt  <= 3'd0;
                bit_cnt   <= 3'd0;
                sh_out    <= req_write ? CMD_WRITE : CMD_READ;
            end

            // Byte boundaries load the next byte; read data and stalls shift out zeros.
            if (fall) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == CMD)  sh_out <= txn_addr;
                    else if (wr_take)  sh_out <= wr_data;
                    else               sh_out <= 8'h00;
                    if (state == DATA) byte_cnt <= byte_cnt + 3'd1;
                end else begin
                    sh_out <= {sh_out[6:0], 1'b0};
                end
            end

            if (state == WAIT_WR && wr_take) sh_out <= wr_data;

            if (rise && state == DATA && !txn_write) begin
                sh_in <= {sh_in[6:0], miso_i};
                if (bit_cnt == 3'd7) begin
                    rd_data  <= {sh_in[6:0], miso_i};
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/spi_sequencer.md
SPI_SEQUENCER -- requirements
Module: spi_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 2..255).
REQ-002 Parameter CS_GAP, default 4, meaning minimum clk cycles cs_n_o stays high between transactions.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  transaction request.
REQ-006 req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-007 req_write  input  1  1 = register write, 0 = register read.
REQ-008 req_addr  input  8  register address.
REQ-009 req_len  input  3  data byte count minus one (1..8 bytes).
REQ-010 wr_data  input  8  next write data byte.
REQ-011 wr_valid  input  1  wr_data valid.
REQ-012 wr_ready  output  1  write byte taken on wr_valid and wr_ready.
REQ-013 rd_data  output  8  last received data byte, held until the next one.
REQ-014 rd_valid  output  1  one-cycle pulse per received data byte.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse when cs_n_o deasserts at end of transaction.
REQ-017 sclk_o  output  1  SPI clock, mode 0 (idle low).
REQ-018 cs_n_o  output  1  chip select, active low.
REQ-019 mosi_o  output  1  serial data out, MSB first.
REQ-020 miso_i  input  1  serial data in, sampled in clk domain.

Function
REQ-021 Frame: command byte (0x0A write, 0x0B read), then req_addr, then req_len+1 data bytes, all under one cs_n_o low period.
REQ-022 States: IDLE, CS_SETUP, CMD, ADDR, DATA, WAIT_WR, CS_HOLD, GAP.
REQ-023 IDLE: req_ready=1; on handshake, latch write/addr/len and go to CS_SETUP; cs_n_o falls on the next cycle.
REQ-024 CS_SETUP lasts CLK_DIV cycles, with mosi_o driving bit 7 of the command; it then goes to CMD.
REQ-025 Each bit is CLK_DIV cycles low then CLK_DIV cycles high on sclk_o; mosi_o changes only on sclk_o falling edges or on entry to a byte; miso_i is sampled on the cycle sclk_o rises.
REQ-026 A byte is 16*CLK_DIV cycles. CMD goes to ADDR, then ADDR goes to DATA after 8 bits.
REQ-027 Write: before each data byte (including the first), wr_ready=1 until wr_valid.
REQ-028 If wr_valid is low at a write byte boundary, go to WAIT_WR: sclk_o held low, cs_n_o held low, no bit timing advances. Resume the cycle after the handshake.
REQ-029 Read: mosi_o=0 during DATA. miso_i is ignored during CMD/ADDR. rd_data updates and rd_valid pulses the cycle after the 8th sampled bit of each data byte.
REQ-030 After the last data byte, CS_HOLD holds sclk_o low for CLK_DIV cycles, then cs_n_o rises and done pulses in the same cycle.
REQ-031 GAP lasts CS_GAP cycles; req_ready stays 0 until IDLE is re-entered, so a request presented during done or GAP waits.
REQ-032 Unstalled cs_n_o low time is 2*CLK_DIV + (req_len+3)*16*CLK_DIV cycles.
REQ-033 Internal byte counter is 3 bits; req_len=7 yields exactly 8 data bytes, with no wrap to an extra byte.
REQ-034 wr_valid outside a wr_ready window is ignored; rd_valid never pulses during write transactions.

Reset
REQ-035 rst forces the following immediately, independent of clk, including mid-byte or mid-stall: state=IDLE, cs_n_o=1, sclk_o=0, mosi_o=0, rd_data=0x00, rd_valid=0, done=0, busy=0, wr_ready=0.
REQ-036 req_ready=1 from the first clk edge after rst deasserts; a partial transaction is never resumed.

Structure
REQ-037 Shared package spi_seq_pkg holds the state encoding, CMD_WRITE=0x0A and CMD_READ=0x0B.
REQ-038 One sub-module, spi_sclk_gen: divider producing sclk_o plus single-cycle rise/fall strobes, with run/hold control from the FSM.

Verification (CLK_DIV=4, CS_GAP=4)
REQ-039 Write, addr 0x2D, len 0, data 0x02 -> MOSI bytes 0x0A,0x2D,0x02; cs_n_o low for 200 cycles; one done pulse.
REQ-040 Read, addr 0x00, len 0; slave returns 0xAD in the data byte -> single rd_valid with rd_data=0xAD; MOSI 0x0B,0x00,0x00.
REQ-041 Burst read, addr 0x0E, len 5; slave returns 0x11..0x16 -> six rd_valid pulses in order; cs_n_o low for 520 cycles.
REQ-042 Write, len 1, wr_valid withheld 100 cycles before the second data byte -> sclk_o low and cs_n_o low throughout the stall; MOSI stream unchanged; cs_n_o low for 364 cycles.
REQ-043 rst asserted mid-ADDR byte -> cs_n_o=1 and sclk_o=0 without waiting for a clk edge; req_ready=1 one clk after release.
REQ-044 Back-to-back requests, req_valid held high -> cs_n_o high for at least 5 cycles between frames; second frame correct.
